// File: rtl/rt_line_access_ctrl.sv
// rt_line_access_ctrl
//   Word-level sequencer for one racetrack line. A single read or write
//   request becomes a train of shift, read and write pulses that walks the
//   track through every offset 0..NSP-1 and then brings it back home.
//   Read bits from every port are assembled into one word.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   request handshake (ready only while idle)
//   req_op_i              00 read data, 01 write data, 10 read lim, 11 illegal
//   req_wdata_i           word to write
//   resp_valid_o          one-cycle completion pulse
//   resp_rdata_o          last assembled read word (held between reads)
//   resp_err_o            set with resp_valid_o for an illegal op
//   shift_s_o, shift_m_o  shift direction (1 = forward) and shift pulse
//   read_current_o        read pulse
//   write_i_o, write_en_o shared write bit value and per-port write enables
//   r_port_data_i         data-plane read ports
//   r_port_lim_i          lim-plane read ports
//   offset_o              current track offset (debug)
//
// NB must be a multiple of NP. Word bit p*NSP+k belongs to port p at offset k.
module rt_line_access_ctrl #(
    parameter int NB        = 32,
    parameter int NP        = 8,
    parameter int SHIFT_CYC = 2,
    parameter int READ_CYC  = 1,
    parameter int WRITE_CYC = 2,
    localparam int NSP      = NB / NP,
    localparam int OW       = (NSP > 1) ? $clog2(NSP) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [1:0]    req_op_i,
    input  logic [NB-1:0] req_wdata_i,
    output logic          resp_valid_o,
    output logic [NB-1:0] resp_rdata_o,
    output logic          resp_err_o,
    output logic          shift_s_o,
    output logic          shift_m_o,
    output logic          read_current_o,
    output logic          write_i_o,
    output logic [NP-1:0] write_en_o,
    input  logic [NP-1:0] r_port_data_i,
    input  logic [NP-1:0] r_port_lim_i,
    output logic [OW-1:0] offset_o
);

    localparam int MAX_SR = (SHIFT_CYC > READ_CYC) ? SHIFT_CYC : READ_CYC;
    localparam int MAXC   = (MAX_SR > WRITE_CYC) ? MAX_SR : WRITE_CYC;
    localparam int CW     = $clog2(MAXC + 1);

    localparam logic [CW-1:0] S_LEN  = CW'(SHIFT_CYC);
    localparam logic [CW-1:0] R_LEN  = CW'(READ_CYC);
    localparam logic [CW-1:0] W_LEN  = CW'(WRITE_CYC);
    localparam logic [CW-1:0] R_LAST = CW'(READ_CYC - 1);
    localparam logic [OW-1:0] K_LAST = OW'(NSP - 1);
    localparam logic [OW-1:0] K_ONE  = OW'(1);

    typedef enum logic [2:0] {IDLE, RD, SHF, WR1, WR0, SHB, RESP} state_t;

    state_t          state, next_state;
    logic [CW-1:0]   cnt;
    logic [OW-1:0]   offset;
    logic [1:0]      op_q;
    logic [NB-1:0]   wdata_q;
    logic [NB-1:0]   acc;
    logic [NB-1:0]   rdata_q;
    logic            err_wait;
    logic [CW-1:0]   phase_len;
    logic            in_phase;
    logic            active;
    logic            gap;
    logic            accept;
    logic [NP-1:0]   col;
    logic [NP-1:0]   bus;

    assign req_ready_o = (state == IDLE) && !rst_i;
    assign accept      = req_valid_i && req_ready_o;
    assign bus         = op_q[1] ? r_port_lim_i : r_port_data_i;

    // Every pulsed state is N active cycles followed by one gap cycle; the
    // cycle counter runs 0..N, so cnt == N marks the gap and the phase end.
    always_comb begin
        phase_len = '0;
        in_phase  = 1'b1;
        case (state)
            RD:       phase_len = R_LEN;
            SHF, SHB: phase_len = S_LEN;
            WR1, WR0: phase_len = W_LEN;
            default:  in_phase  = 1'b0;
        endcase
    end

    assign active = in_phase && (cnt < phase_len);
    assign gap    = in_phase && (cnt == phase_len);

    // Column of the latched write word that lines up with the ports at the
    // current offset.
    always_comb begin
        col = '0;
        for (int p = 0; p < NP; p++) begin
            col[p] = wdata_q[p*NSP + int'(offset)];
        end
    end

    // Next-state logic. Reads and writes share the offset walk: visit every
    // offset, shifting forward between them, then shift back home. An
    // illegal op spends one quiet cycle in RESP (err_wait) before responding.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (req_op_i)
                        2'b01:   next_state = WR1;
                        2'b11:   next_state = RESP;
                        default: next_state = RD;
                    endcase
                end
            end
            RD, WR0: begin
                if (gap) begin
                    if (offset == K_LAST) begin
                        next_state = (NSP > 1) ? SHB : RESP;
                    end else begin
                        next_state = SHF;
                    end
                end
            end
            WR1: begin
                if (gap) next_state = WR0;
            end
            SHF: begin
                if (gap) next_state = (op_q == 2'b01) ? WR1 : RD;
            end
            SHB: begin
                if (gap && (offset == K_ONE)) next_state = RESP;
            end
            RESP: begin
                if (!err_wait) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Strobes are decoded straight from the state so that a reset returns
    // them to zero on the very next cycle. write_i_o and shift_s_o are levels
    // that stay put through the gap cycle.
    always_comb begin
        shift_s_o      = (state == SHF);
        shift_m_o      = active && ((state == SHF) || (state == SHB));
        read_current_o = active && (state == RD);
        write_i_o      = (state == WR1);
        write_en_o     = '0;
        if (active && (state == WR1)) begin
            write_en_o = col;
        end else if (active && (state == WR0)) begin
            write_en_o = ~col;
        end
    end

    assign resp_valid_o = (state == RESP) && !err_wait;
    assign resp_err_o   = resp_valid_o && (op_q == 2'b11);
    assign resp_rdata_o = rdata_q;
    assign offset_o     = offset;

    // State register plus datapath. The port bus is captured on the last
    // active read cycle; the finished word is published only when a read
    // moves into RESP, so writes and illegal ops leave resp_rdata_o alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            offset   <= '0;
            op_q     <= '0;
            wdata_q  <= '0;
            acc      <= '0;
            rdata_q  <= '0;
            err_wait <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= (in_phase && !gap) ? cnt + CW'(1) : '0;

            if (accept) begin
                op_q     <= req_op_i;
                wdata_q  <= req_wdata_i;
                err_wait <= (req_op_i == 2'b11);
            end else if (state == RESP) begin
                err_wait <= 1'b0;
            end

            if (gap && (state == SHF)) begin
                offset <= offset + OW'(1);
            end else if (gap && (state == SHB)) begin
                offset <= offset - OW'(1);
            end

            if ((state == RD) && (cnt == R_LAST)) begin
                for (int p = 0; p < NP; p++) begin
                    acc[p*NSP + int'(offset)] <= bus[p];
                end
            end

            if (((state == RD) || (state == SHB)) && (next_state == RESP) && !op_q[0]) begin
                rdata_q <= acc;
            end
        end
    end

endmodule

// File: doc/rt_line_access_ctrl.md
Name: rt_line_access_ctrl

Overview:
- Word-level sequencer that drives one racetrack line (NB bits, NP read/write ports, NSP = NB/NP bits per port) and converts single-word read/write requests into shift, read and write pulse trains.
- Captures the per-port read bits and assembles a full word.
- Sits between the LiM memory controller and the racetrack line model; every line plane shares this block's shift pulses.

Parameters:
- NB, 32, bits per line; NB % NP == 0 required.
- NP, 8, number of access ports.
- SHIFT_CYC, 2, cycles shift_m_o is held high per shift pulse (>=1).
- READ_CYC, 1, cycles read_current_o is held high per read pulse (>=1).
- WRITE_CYC, 2, cycles write_en_o is held active per write pulse (>=1).
- Derived: NSP = NB/NP.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  high only in IDLE.
- req_op_i  in  2  00 read data, 01 write data, 10 read lim, 11 illegal.
- req_wdata_i  in  NB  write word.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_rdata_o  out  NB  assembled read word; held until next response.
- resp_err_o  out  1  qualifies resp_valid_o; set for op 11.
- shift_s_o  out  1  shift direction (1 = forward).
- shift_m_o  out  1  shift pulse waveform.
- read_current_o  out  1  read pulse.
- write_i_o  out  1  shared write bit value.
- write_en_o  out  NP  per-port write enable.
- r_port_data_i  in  NP  data-plane read ports.
- r_port_lim_i  in  NP  lim-plane read ports.
- offset_o  out  clog2(NSP) (min 1)  current track offset, for debug.

Behaviour:
- Reset: state IDLE, offset 0, and every output 0, including resp_rdata_o.
- Reset is honoured mid-operation; the physical track is not realigned, and software must reinitialise the line.
- Handshake: the request is accepted at the clock edge where req_valid_i && req_ready_o. Op and wdata are latched at that edge, and req_ready_o drops in the next cycle.
- Bit mapping: word bit p*NSP+k corresponds to port p at offset k. Offset 0 is home.
- Pulse shape: each phase is N cycles active followed by 1 gap cycle with all strobes low.
  - Shift phase: N = SHIFT_CYC; shift_s_o stays stable through the gap.
  - Read phase: N = READ_CYC.
  - Write phase: N = WRITE_CYC.
- FSM states: IDLE, RD, SHF, WR1, WR0, SHB, RESP.
- Read op, for k = 0..NSP-1:
  - If k > 0, do SHF: forward shift, offset+1.
  - Then RD. The selected port bus (data for op 00, lim for op 10) is sampled on the last active RD cycle into bits p*NSP+k.
- Write op, for each k:
  - SHF if k > 0.
  - WR1: write_i_o=1, write_en_o[p]=wdata[p*NSP+k].
  - WR0: write_i_o=0, write_en_o[p]=~wdata[p*NSP+k].
  - write_en_o is active only in active cycles; write_i_o is held through the gap.
  - WR1 and WR0 are always executed, even if the enables are all zero, so latency is fixed.
- After the last offset: NSP-1 SHB phases (shift_s_o=0, offset-1) return the track to offset 0.
- RESP: resp_valid_o=1 for one cycle, then IDLE.
  - resp_rdata_o updates only on reads.
  - Writes leave resp_rdata_o unchanged.
- Op 11: no pulses are issued; RESP is entered the cycle after acceptance with resp_err_o=1 and resp_rdata_o unchanged.
- NSP == 1: no SHF or SHB phases.
- Latency (accept edge to the edge at which resp_valid_o is sampled high):
  - Read: NSP*(READ_CYC+1) + 2*(NSP-1)*(SHIFT_CYC+1) + 1. Defaults: 27.
  - Write: 2*NSP*(WRITE_CYC+1) + 2*(NSP-1)*(SHIFT_CYC+1) + 1. Defaults: 43.
  - Illegal op: 2.
- Invariants: never more than one strobe active in the same cycle; offset_o is 0 whenever IDLE; req_valid_i is ignored while busy.

Test Plan:
- Reset: assert rst_i for 2 cycles while issuing a read -> all outputs 0, req_ready_o=1 on the first cycle after reset.
- Write 0xA5C3_0F96 (op 01) -> 43-cycle latency. At offset k, the WR1 enables equal {wdata[7*4+k],...,wdata[k]}; 3 forward and 3 backward shifts; offset_o=0 at RESP.
- Read data (op 00) with a line model preloaded by the previous write -> resp_rdata_o=0xA5C3_0F96 after 27 cycles; exactly 4 read pulses, each 1 cycle wide with a gap.
- Read lim (op 10) with r_port_lim_i driven 0xFF at offsets 0 and 2 and 0x00 at offsets 1 and 3 -> resp_rdata_o=0x5555_5555.
- Op 11 -> resp_valid_o and resp_err_o high 2 cycles after acceptance; no strobe ever asserted; back-to-back request accepted in the cycle after RESP.
- Assert rst_i during the second SHF of a write -> next cycle IDLE, all strobes 0, offset_o=0, no resp_valid_o.
